camera_frame_packer: RTL and testbench
======================================

CAMERA_FRAME_PACKER -- requirements
Module: camera_frame_packer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 38400, meaning the number of 128-bit words per 640x480 RGB565 frame.
REQ-002 SHALL have port clk_25M, input, 1, the single clock.
REQ-003 SHALL have port rst_25M, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have the following data-side ports:
- hdr_en, input, 1: enable three-exposure rotation.
- vsync, input, 1: frame-start pulse.
- pix_data, input, 16: RGB565 pixel.
- pix_valid, input, 1: pixel strobe.
REQ-005 SHALL have the following write-side ports:
- wr_ack, input, 1: SDRAM arbiter accepted the word.
- camera_wr_req, output, 1: word pending.
- camera_data, output, 128: packed word.
- wr_address, output, 27: word address.
REQ-006 SHALL have the following status ports:
- last_frame, output, 3: slot code of the frame being written.
- exposure_sel, output, 2: 0 = low, 1 = mid, 2 = high, for the sensor.
- frame_done, output, 1: one-cycle end-of-frame pulse.
- overflow, output, 1: sticky.
- frame_err, output, 1: sticky.

Function
REQ-007 SHALL pack 8 accepted pixels per word: pixel 0 goes to bits [15:0] and pixel 7 to bits [127:112].
REQ-008 SHALL assert camera_wr_req the cycle after the 8th pixel of a word is accepted, and hold camera_data and wr_address stable until wr_ack.
REQ-009 SHALL consume a word on any cycle where camera_wr_req and wr_ack are both 1; camera_wr_req SHALL drop the next cycle unless another word is queued.
REQ-010 SHALL ignore wr_ack while camera_wr_req is 0.
REQ-011 SHALL use the slot sequence 000, 001, 101, 100, 110, 010 and then wrap to 000.
REQ-012 SHALL map slot codes to base addresses and exposures as follows:
- 000 -> 0x0, low
- 001 -> 0x4B000, mid
- 101 -> 0x96000, high
- 100 -> 0xE1000, low
- 110 -> 0x12C000, mid
- 010 -> 0x177000, high
REQ-013 SHALL set wr_address to the slot base at frame start and add 8 after each consumed word.
REQ-014 SHALL implement the FSM IDLE -> CAPTURE -> FLUSH -> DONE -> IDLE:
- IDLE: ignore pixels; go to CAPTURE on vsync.
- CAPTURE: pack pixels; go to FLUSH once FRAME_WORDS words have been queued.
- FLUSH: ignore pixels; go to DONE once the last word is acknowledged.
- DONE: pulse frame_done for one cycle and advance the slot; then return to IDLE.
REQ-015 SHALL update last_frame and exposure_sel on the cycle after frame_done.
REQ-016 SHALL, when hdr_en=0 at DONE, keep the slot unchanged, so the same buffer is rewritten.
REQ-017 SHALL handle vsync in CAPTURE or FLUSH (short frame) as follows:
- set frame_err;
- discard the partial word and any queued words;
- deassert camera_wr_req;
- restart CAPTURE at the same slot base without advancing the slot and without pulsing frame_done.
REQ-018 SHALL handle a completed word that finds the queue full by dropping it, setting overflow, and still advancing the word count.
REQ-019 SHALL, when vsync and pix_valid arrive in the same cycle, start the frame and accept that pixel as pixel 0.
REQ-020 SHALL leave overflow and frame_err set until reset.

Reset
REQ-021 SHALL, on rst_25M=1, put the FSM in IDLE and clear the pack counter and the queue.
REQ-022 SHALL, on reset, drive the outputs to: camera_wr_req=0, camera_data=0, wr_address=0, last_frame=000, exposure_sel=0, frame_done=0, overflow=0, frame_err=0.
REQ-023 SHALL accept reset mid-frame and abort the frame without pulsing frame_done.

Configuration
REQ-024 SHALL, when CAMERA_PACKER_FIFO_EN is defined, queue words in a 4-entry FIFO; camera_data and wr_address SHALL come from the FIFO head, and each entry SHALL store its own address.
REQ-025 SHALL, when CAMERA_PACKER_FIFO_EN is undefined, use a single holding register as a queue of depth 1.

Structure
REQ-026 SHALL place the slot codes, base addresses, exposure encodings, words-per-frame constant and FSM state encoding in shared package hdr_pkg; image_generator SHALL use the same slot constants.
REQ-027 SHALL implement the FIFO as sub-module packer_word_fifo (depth 4, 155-bit entries, full/empty flags), instantiated only under CAMERA_PACKER_FIFO_EN.

Verification
REQ-028 SHALL cover these directed scenarios:
- Pack order: vsync, then pixels 0x0001..0x0008 with wr_ack tied to 1 -> camera_data=0x0008_0007_..._0001 at wr_address 0x0, one cycle after pixel 8.
- Full frame: FRAME_WORDS=4, 32 pixels -> addresses 0x0, 0x8, 0x10, 0x18; frame_done pulse; then last_frame=001 and exposure_sel=1.
- Rotation: six frames with hdr_en=1 -> codes 001, 101, 100, 110, 010, 000 and bases per REQ-012; with hdr_en=0 the code stays at 000.
- Backpressure: wr_ack=0 for 20 cycles while 16 pixels arrive -> without the macro overflow=1 and one word is dropped; with the macro no overflow and 2 words are delivered in order.
- Short frame: vsync after 12 pixels -> frame_err=1, no frame_done, next word at the same base 0x0.
- Reset mid-frame: rst_25M for 1 cycle during CAPTURE -> all outputs at reset values the next cycle; IDLE until vsync.

Source files
------------

// File: rtl/hdr_pkg.sv
// hdr_pkg: HDR slot codes, buffer base addresses, exposure codes, frame size and packer FSM states.
// Exports constants and the helpers next_slot, slot_base and slot_exposure; no ports.
package hdr_pkg;
  localparam int FRAME_WORDS_DEF = 38400;
  localparam logic [2:0] SLOT_0 = 3'b000, SLOT_1 = 3'b001, SLOT_2 = 3'b101,
                         SLOT_3 = 3'b100, SLOT_4 = 3'b110, SLOT_5 = 3'b010;
  localparam logic [26:0] BASE_0 = 27'h0, BASE_1 = 27'h4B000, BASE_2 = 27'h96000,
                          BASE_3 = 27'hE1000, BASE_4 = 27'h12C000, BASE_5 = 27'h177000;
  localparam logic [1:0] EXP_LOW = 2'd0, EXP_MID = 2'd1, EXP_HIGH = 2'd2;
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
  // Codes outside the rotation fall back to slot 0.
  function automatic logic [2:0] next_slot(input logic [2:0] s);
    return s == SLOT_0 ? SLOT_1 : s == SLOT_1 ? SLOT_2 : s == SLOT_2 ? SLOT_3 :
           s == SLOT_3 ? SLOT_4 : s == SLOT_4 ? SLOT_5 : SLOT_0;
  endfunction
  function automatic logic [26:0] slot_base(input logic [2:0] s);
    return s == SLOT_1 ? BASE_1 : s == SLOT_2 ? BASE_2 : s == SLOT_3 ? BASE_3 :
           s == SLOT_4 ? BASE_4 : s == SLOT_5 ? BASE_5 : BASE_0;
  endfunction
  function automatic logic [1:0] slot_exposure(input logic [2:0] s);
    return (s == SLOT_1 || s == SLOT_4) ? EXP_MID : (s == SLOT_2 || s == SLOT_5) ? EXP_HIGH : EXP_LOW;
  endfunction
endpackage

// File: rtl/packer_word_fifo.sv
// packer_word_fifo: 4-entry FIFO of {address, data} words for the camera frame packer.
// Ports: clk/rst clock and sync reset; flush empties the FIFO; push/din write; pop advances the head;
// dout is the head entry; full/empty flags. The caller pushes only when !full or popping in the same cycle.
module packer_word_fifo (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [154:0] din,
  output logic [154:0] dout,
  output logic         full,
  output logic         empty
);
  logic [154:0] mem_q [4];
  logic [154:0] mem_d [4];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = flush ? 2'd0 : wp_q + 2'(push);
    rp_d = flush ? 2'd0 : rp_q + 2'(pop);
    cnt_d = flush ? 3'd0 : cnt_q + 3'(push) - 3'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= 2'd0;
      rp_q <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rp_q];
  assign full = cnt_q == 3'd4;
  assign empty = cnt_q == 3'd0;
endmodule

// File: rtl/camera_frame_packer.sv
// camera_frame_packer: packs RGB565 pixels into 128-bit SDRAM words and rotates HDR exposure buffers.
// Ports: clk_25M/rst_25M clock and sync active-high reset; hdr_en, vsync, pix_data, pix_valid camera side;
// wr_ack in, camera_wr_req/camera_data/wr_address out to the SDRAM arbiter; last_frame, exposure_sel,
// frame_done, overflow, frame_err status. Define CAMERA_PACKER_FIFO_EN to queue words in a 4-entry FIFO
// instead of a single holding register.
module camera_frame_packer
  import hdr_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic         clk_25M,
  input  logic         rst_25M,
  input  logic         hdr_en,
  input  logic         vsync,
  input  logic [15:0]  pix_data,
  input  logic         pix_valid,
  input  logic         wr_ack,
  output logic         camera_wr_req,
  output logic [127:0] camera_data,
  output logic [26:0]  wr_address,
  output logic [2:0]   last_frame,
  output logic [1:0]   exposure_sel,
  output logic         frame_done,
  output logic         overflow,
  output logic         frame_err
);
  localparam int WCW = $clog2(FRAME_WORDS + 1);
  state_t state_q, state_d;
  logic [2:0] pcnt_q, pcnt_d, pc;
  logic [111:0] pack_q, pack_d;
  logic [WCW-1:0] wcnt_q, wcnt_d, wc;
  logic [26:0] addr_q, addr_d, ad;
  logic [2:0] slot_q, slot_d;
  logic [1:0] exp_q, exp_d;
  logic done_q, done_d, ovf_q, ovf_d, ferr_q, ferr_d;
  logic start, restart, take, word_ok, push, pop, full, empty;
  logic [154:0] head;
  // A frame (re)start zeroes the pack/word counters and rebases the address in the same cycle,
  // so a pixel arriving with vsync lands as pixel 0. addr_q is the address of the next queued word.
  always_comb begin
    start = vsync && state_q != DONE;
    restart = start && state_q != IDLE;
    take = pix_valid && (start || state_q == CAPTURE);
    pc = start ? 3'd0 : pcnt_q;
    wc = start ? '0 : wcnt_q;
    ad = start ? slot_base(slot_q) : addr_q;
    word_ok = take && pc == 3'd7;
    pop = !empty && wr_ack && !restart;
    push = word_ok && (!full || pop);
    pack_d = pack_q;
    if (take && !word_ok) pack_d[{pc, 4'b0} +: 16] = pix_data;
    pcnt_d = take ? pc + 3'd1 : pc;
    wcnt_d = word_ok ? wc + 1'b1 : wc;
    addr_d = push ? ad + 27'd8 : ad;
    state_d = start ? CAPTURE
            : state_q == CAPTURE ? (word_ok && wc == WCW'(FRAME_WORDS - 1) ? FLUSH : CAPTURE)
            : state_q == FLUSH ? (empty ? DONE : FLUSH)
            : IDLE;
    done_d = state_d == DONE;
    slot_d = (state_q == DONE && hdr_en) ? next_slot(slot_q) : slot_q;
    exp_d = slot_exposure(slot_d);
    ovf_d = ovf_q || (word_ok && !push);
    ferr_d = ferr_q || restart;
  end
  always_ff @(posedge clk_25M) begin
    if (rst_25M) begin
      state_q <= IDLE;
      pcnt_q <= 3'd0;
      pack_q <= '0;
      wcnt_q <= '0;
      addr_q <= '0;
      slot_q <= SLOT_0;
      exp_q <= EXP_LOW;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      pack_q <= pack_d;
      wcnt_q <= wcnt_d;
      addr_q <= addr_d;
      slot_q <= slot_d;
      exp_q <= exp_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      ferr_q <= ferr_d;
    end
  end
`ifdef CAMERA_PACKER_FIFO_EN
  packer_word_fifo u_fifo (
    .clk  (clk_25M),
    .rst  (rst_25M),
    .flush(restart),
    .push (push),
    .pop  (pop),
    .din  ({ad, pix_data, pack_q}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
`else
  logic hold_v_q, hold_v_d;
  logic [154:0] hold_q, hold_d;
  always_comb begin
    hold_v_d = !restart && (push || (hold_v_q && !pop));
    hold_d = push ? {ad, pix_data, pack_q} : hold_q;
  end
  always_ff @(posedge clk_25M) begin
    if (rst_25M) begin
      hold_v_q <= 1'b0;
      hold_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_q <= hold_d;
    end
  end
  assign full = hold_v_q;
  assign empty = !hold_v_q;
  assign head = hold_q;
`endif
  // With nothing queued the address shows where the next word will go.
  assign camera_wr_req = !empty;
  assign camera_data = head[127:0];
  assign wr_address = empty ? addr_q : head[154:128];
  assign last_frame = slot_q;
  assign exposure_sel = exp_q;
  assign frame_done = done_q;
  assign overflow = ovf_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_camera_frame_packer.sv
// tb_camera_frame_packer: randomized and directed bench with a queue-level reference model.
module tb_camera_frame_packer;
  localparam int FW = 4;
`ifdef CAMERA_PACKER_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk_25M = 1'b0, rst_25M = 1'b0, hdr_en = 1'b0, vsync = 1'b0, pix_valid = 1'b0, wr_ack = 1'b0;
  logic [15:0] pix_data = '0;
  logic camera_wr_req, frame_done, overflow, frame_err;
  logic [127:0] camera_data;
  logic [26:0] wr_address;
  logic [2:0] last_frame;
  logic [1:0] exposure_sel;
  camera_frame_packer #(.FRAME_WORDS(FW)) dut (
    .clk_25M(clk_25M), .rst_25M(rst_25M), .hdr_en(hdr_en), .vsync(vsync), .pix_data(pix_data),
    .pix_valid(pix_valid), .wr_ack(wr_ack), .camera_wr_req(camera_wr_req), .camera_data(camera_data),
    .wr_address(wr_address), .last_frame(last_frame), .exposure_sel(exposure_sel),
    .frame_done(frame_done), .overflow(overflow), .frame_err(frame_err)
  );
  always #5 clk_25M = ~clk_25M;
  logic [2:0] codes [6] = '{3'b000, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
  logic [26:0] bases [6] = '{27'h0, 27'h4B000, 27'h96000, 27'hE1000, 27'h12C000, 27'h177000};
  logic [1:0] exps [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [26:0] rot_base [5] = '{27'h4B000, 27'h96000, 27'hE1000, 27'h12C000, 27'h177000};
  logic [2:0] rot_code [5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b000};
  int errors = 0, checks = 0;
  bit chk_on = 0;
  logic [154:0] mq[$];
  logic [15:0] mpix[$];
  bit m_cap, m_flush, m_done, m_ovf, m_ferr;
  int m_slot, m_words, m_enq;
  logic [26:0] m_base;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask
  // Frame-level model: queue of expected words, pixel list, slot index.
  task automatic model_step(input logic r, vs, pv, input logic [15:0] pd, input logic ack, h);
    bit pre_empty, pop;
    logic [127:0] w;
    if (r) begin
      mq.delete(); mpix.delete();
      m_cap = 0; m_flush = 0; m_done = 0; m_ovf = 0; m_ferr = 0;
      m_slot = 0; m_words = 0; m_enq = 0; m_base = '0;
      return;
    end
    pre_empty = mq.size() == 0;
    pop = !pre_empty && ack;
    if (m_done) begin
      m_done = 0;
      if (h) m_slot = (m_slot + 1) % 6;
    end else if (vs) begin
      if (m_cap || m_flush) begin
        m_ferr = 1; mq.delete(); pop = 0;
      end
      m_cap = 1; m_flush = 0; mpix.delete(); m_words = 0; m_enq = 0; m_base = bases[m_slot];
    end else if (m_flush && pre_empty) begin
      m_flush = 0; m_done = 1;
    end
    if (pop) void'(mq.pop_front());
    if (m_cap && pv) begin
      mpix.push_back(pd);
      if (mpix.size() == 8) begin
        w = '0;
        for (int i = 0; i < 8; i++) w[16*i +: 16] = mpix[i];
        mpix.delete();
        m_words++;
        if (mq.size() < DEPTH) begin
          mq.push_back({m_base + 27'(8 * m_enq), w});
          m_enq++;
        end else m_ovf = 1;
        if (m_words == FW) begin
          m_cap = 0; m_flush = 1;
        end
      end
    end
  endtask
  task automatic cyc(input logic r, vs, pv, input logic [15:0] pd, input logic ack, h);
    rst_25M = r; vsync = vs; pix_valid = pv; pix_data = pd; wr_ack = ack; hdr_en = h;
    @(posedge clk_25M);
    model_step(r, vs, pv, pd, ack, h);
    #1;
  endtask
  task automatic rand_cyc(input logic h);
    cyc(1'b0, 1'b0, $urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6, h);
  endtask
  task automatic wait_done(input logic h);
    int n = 0;
    while (frame_done !== 1'b1 && n < 60) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, h);
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, h);
  endtask
  task automatic finish_frame(input logic h);
    int n = 0;
    while (m_cap && n < 1000) begin
      rand_cyc(h);
      n++;
    end
    chk("capture_bound", n < 1000, 1);
    wait_done(h);
  endtask
  task automatic chk_reset_vals();
    chk("rst_req", camera_wr_req, 0);
    chk("rst_data", camera_data, 0);
    chk("rst_addr", wr_address, 0);
    chk("rst_last_frame", last_frame, 0);
    chk("rst_exposure", exposure_sel, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
  endtask
  always @(negedge clk_25M) begin
    if (chk_on) begin
      chk("wr_req", camera_wr_req, mq.size() != 0);
      if (mq.size() != 0) chk("data", camera_data, mq[0][127:0]);
      chk("addr", wr_address, mq.size() != 0 ? mq[0][154:128] : m_base + 27'(8 * m_enq));
      chk("frame_done", frame_done, m_done);
      chk("last_frame", last_frame, codes[m_slot]);
      chk("exposure_sel", exposure_sel, exps[m_slot]);
      chk("overflow", overflow, m_ovf);
      chk("frame_err", frame_err, m_ferr);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n;
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk_on = 1;
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk_reset_vals();
    // Pack order and full frame at slot 000.
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    for (int p = 1; p <= 32; p++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'(p), 1'b1, 1'b1);
      if (p == 8) begin
        chk("pack_req", camera_wr_req, 1);
        chk("pack_data", camera_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      end
      if (p % 8 == 0) chk("frame_addr", wr_address, 27'((p / 8 - 1) * 8));
    end
    wait_done(1'b1);
    chk("frame1_code", last_frame, 3'b001);
    chk("frame1_exp", exposure_sel, 2'd1);
    // Backpressure at slot 001 with hdr_en low.
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int p = 0; p < 16; p++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("bp_overflow", overflow, DEPTH == 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (camera_wr_req) n++;
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    end
    chk("bp_delivered", n, DEPTH == 1 ? 1 : 2);
    for (int p = 0; p < 16; p++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b1, 1'b0);
    wait_done(1'b0);
    chk("hold_code_001", last_frame, 3'b001);
    // Rotation through the remaining slots with random traffic.
    for (int f = 0; f < 5; f++) begin
      cyc(1'b0, 1'b1, $urandom_range(0, 1) == 1, 16'($urandom), 1'b1, 1'b1);
      chk("rot_base", wr_address, rot_base[f]);
      finish_frame(1'b1);
      chk("rot_code", last_frame, rot_code[f]);
    end
    // Short frame at slot 000, pixel accepted together with vsync.
    cyc(1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int p = 0; p < 11; p++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("short_frame_err", frame_err, 1);
    for (int p = 0; p < 8; p++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
    chk("short_req", camera_wr_req, 1);
    chk("short_addr", wr_address, 27'h0);
    finish_frame(1'b0);
    chk("hold_code_000", last_frame, 3'b000);
    // Reset in the middle of a frame.
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int p = 0; p < 10; p++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
    chk_reset_vals();
    for (int p = 0; p < 10; p++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b1, 1'b1);
    chk("idle_after_rst", camera_wr_req, 0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    finish_frame(1'b1);
    chk("post_rst_code", last_frame, 3'b001);
    @(negedge clk_25M);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
